// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity-mode constants and the parity-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // ones_xor is the XOR-reduction of the payload (1 when it holds an odd
  // number of ones); even parity repeats it, odd parity inverts it.
  function automatic logic parity_bit(input logic ones_xor, input int mode);
    return (mode == PAR_ODD) ? ~ones_xor : ones_xor;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and pulses bit_end on the
// last clock of every bit period. clear holds the count at zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running count while enabled, wrapping to zero at the end of a bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS payload LSB first,
// optional even/odd parity, one or two stop bits. data_out, busy and done
// are all registered so the serial line never glitches.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 data_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_t            state, state_nxt;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 data_out_nxt, busy_nxt, done_nxt;
  logic                 bit_end;
  logic                 accept;

  // The timer only runs while a frame is on the line, so every frame
  // starts with a full-length start bit.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_IDLE),
    .bit_end(bit_end)
  );

  // Ready is withheld during reset so nothing can be accepted while rst=1.
  assign tx_ready = (state == ST_IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;

  // Next-state and next-output decode; the registered outputs are computed
  // one cycle ahead so the line changes exactly on the bit boundary.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    par_bit_nxt  = par_bit;
    data_out_nxt = 1'b1;
    busy_nxt     = 1'b1;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (accept) begin
          state_nxt    = ST_START;
          shreg_nxt    = tx_data;
          par_bit_nxt  = parity_bit(^tx_data, PARITY);
          bit_cnt_nxt  = 4'd0;
          data_out_nxt = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      ST_START: begin
        data_out_nxt = 1'b0;
        if (bit_end) begin
          state_nxt    = ST_DATA;
          data_out_nxt = shreg[0];
        end
      end
      ST_DATA: begin
        data_out_nxt = shreg[0];
        if (bit_end) begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nxt = 4'd0;
            if (PARITY != PAR_NONE) begin
              state_nxt    = ST_PARITY;
              data_out_nxt = par_bit;
            end else begin
              state_nxt    = ST_STOP;
              data_out_nxt = 1'b1;
            end
          end else begin
            bit_cnt_nxt  = bit_cnt + 4'd1;
            shreg_nxt    = shreg >> 1;
            data_out_nxt = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        data_out_nxt = par_bit;
        if (bit_end) begin
          state_nxt    = ST_STOP;
          data_out_nxt = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = 4'd0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Control state and line outputs; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= 4'd0;
      data_out <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      data_out <= data_out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Payload and parity hold; always reloaded on accept, so no reset needed.
  always_ff @(posedge clk) begin
    shreg   <= shreg_nxt;
    par_bit <= par_bit_nxt;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868; clock cycles per serial bit, legal range 1..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8; data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0; 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1; single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port tx_valid, input, 1; frame request.
REQ-008 SHALL have port tx_ready, output, 1; block can accept a frame.
REQ-009 SHALL have port tx_data, input, DATA_BITS; payload, sampled only on accept.
REQ-010 SHALL have port data_out, output, 1; serial line, idle high.
REQ-011 SHALL have port busy, output, 1; frame in progress.
REQ-012 SHALL have port done, output, 1; one-cycle frame-complete pulse.

Function
REQ-013 SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-014 SHALL drive tx_ready=1 only in IDLE; accept occurs in a cycle with tx_valid=1 and tx_ready=1.
REQ-015 SHALL latch tx_data and compute the parity bit in the accept cycle; later changes to tx_data are ignored.
REQ-016 SHALL ignore tx_valid while not in IDLE; no queuing and no error flag.
REQ-017 SHALL drive data_out=0 and busy=1 from the cycle after accept (T+1).
REQ-018 SHALL hold every bit (start, data, parity, stop) for exactly CLKS_PER_BIT cycles.
REQ-019 SHALL send data bits LSB first.
REQ-020 SHALL set the even-parity bit so that the total number of ones in data plus parity is even; the odd-parity bit makes that total odd.
REQ-021 SHALL drive data_out=1 for STOP_BITS bit periods.
REQ-022 SHALL give N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS; the frame occupies cycles T+1..T+N*CLKS_PER_BIT.
REQ-023 SHALL, at cycle T+N*CLKS_PER_BIT+1, return to IDLE with data_out=1, busy=0, tx_ready=1, and done=1 for exactly that cycle.
REQ-024 SHALL allow a new accept in the done cycle (back-to-back); minimum accept spacing is N*CLKS_PER_BIT+1 cycles.
REQ-025 SHALL size the baud counter to $clog2(CLKS_PER_BIT) with a minimum of 1 bit; with CLKS_PER_BIT=1 each bit lasts one cycle.
REQ-026 SHALL wrap the baud counter to 0 at CLKS_PER_BIT-1; the bit counter advances only on that wrap.
REQ-027 SHALL keep data_out glitch-free: data_out is a flop output, never decoded combinationally.

Reset
REQ-028 SHALL, on rst=1, immediately force state=IDLE, data_out=1, busy=0, done=0, tx_ready=1 (after release) and zero all counters.
REQ-029 SHALL abort a frame reset mid-transmission silently: no done pulse, and the line returns high at once.
REQ-030 SHALL NOT accept a frame in any cycle in which rst=1.

Structure
REQ-031 SHALL place in shared package uart_pkg: the state encoding and the parity-mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2).
REQ-032 SHALL use one sub-module, uart_baud_tick: a CLKS_PER_BIT counter with clear input and bit_end pulse output; the FSM lives in uart_tx_param.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-033 SHALL cover: DATA_BITS=8, PARITY=1, 0xA5 accepted at T -> data_out sequence 0,1,0,1,0,0,1,0,1,0,1, 4 cycles each, done at T+45.
REQ-034 SHALL cover: DATA_BITS=7, PARITY=2, STOP_BITS=2, 0x07 -> 0,1,1,1,0,0,0,0,0,1,1, done at T+45.
REQ-035 SHALL cover: PARITY=0, STOP_BITS=1, tx_valid held high with 0x00 then 0xFF -> second start bit at T+42, i.e. one cycle after the first done at T+41; tx_ready low in between.
REQ-036 SHALL cover: tx_data changed and tx_valid pulsed mid-frame -> transmitted bits unchanged, no extra frame.
REQ-037 SHALL cover: rst asserted at T+13 -> data_out=1 and busy=0 the same cycle, no done; a new frame accepted after release is transmitted correctly.
REQ-038 SHALL cover: CLKS_PER_BIT=1, DATA_BITS=5, 0x15 -> 0,1,0,1,0,1,1 one cycle each, done at T+8.
